axis_echo_xform: RTL and testbench

AXIS_ECHO_XFORM -- requirements
Module: axis_echo_xform

---
 rtl/axis_echo_pkg.sv | 22 ++
 rtl/ascii_case_xform.sv | 22 ++
 rtl/axis_echo_xform.sv | 119 +++++++++++
 tb/tb_axis_echo_xform.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_echo_pkg.sv
// Shared types and ASCII constants for the echo/case-transform byte path.
package axis_echo_pkg;

    typedef enum logic [1:0] {
        XF_PASS  = 2'd0,
        XF_INV   = 2'd1,
        XF_UPPER = 2'd2,
        XF_LOWER = 2'd3
    } xf_mode_e;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z)) ||
               ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z));
    endfunction

endpackage

// File: rtl/ascii_case_xform.sv
// Combinational case transform: bit 5 of an ASCII letter selects its case.
module ascii_case_xform
    import axis_echo_pkg::*;
(
    input  xf_mode_e    mode_i,
    input  logic [7:0]  byte_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = byte_i;
        if (is_letter(byte_i)) begin
            case (mode_i)
                XF_INV:   byte_o[5] = ~byte_i[5];
                XF_UPPER: byte_o[5] = 1'b0;
                XF_LOWER: byte_o[5] = 1'b1;
                default:  byte_o    = byte_i;
            endcase
        end
    end

endmodule

// File: rtl/axis_echo_xform.sv
// UART echo buffer: case-transforms bytes on write, optionally holds them until CR,
// and streams committed bytes out through a registered RAM read and an output register.
module axis_echo_xform
    import axis_echo_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     sresetn,
    input  logic [1:0]               mode,
    input  logic                     line_mode,
    input  logic                     s_axis_tvalid,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [7:0]               m_axis_tdata,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;
    localparam cnt_t FULL   = cnt_t'(DEPTH);
    localparam cnt_t ALMOST = cnt_t'(DEPTH - 1);

    // Pointers carry one wrap bit so equal addresses still tell empty from full.
    cnt_t wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    cnt_t fill_q, fill_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic r_vld_q, r_vld_d;
    logic [7:0] rdata_q;
    logic m_vld_q, m_vld_d;
    logic [7:0] m_data_q, m_data_d;

    logic [7:0] mem [DEPTH];
    logic [7:0] xf_byte;
    logic full, wr_en, drop, commit, rd_en, out_adv, xfer;

    ascii_case_xform u_xform (
        .mode_i (xf_mode_e'(mode)),
        .byte_i (s_axis_tdata),
        .byte_o (xf_byte)
    );

    always_comb begin
        full    = (fill_q == FULL);
        wr_en   = sresetn && s_axis_tvalid && !full;
        drop    = sresetn && s_axis_tvalid && full;
        xfer    = m_vld_q && m_axis_tready;
        out_adv = !m_vld_q || m_axis_tready;
        rd_en   = (cm_q != rd_q) && (!r_vld_q || out_adv);
        // The write that fills the buffer forces a flush so a CR-less line cannot deadlock.
        commit  = !line_mode ||
                  (wr_en && ((s_axis_tdata == ASCII_CR) || (fill_q == ALMOST)));
    end

    always_comb begin
        wr_d = wr_q + cnt_t'(wr_en);
        cm_d = commit ? wr_d : cm_q;
        rd_d = rd_q + cnt_t'(rd_en);

        fill_d = fill_q;
        case ({wr_en, xfer})
            2'b10:   fill_d = fill_q + cnt_t'(1);
            2'b01:   fill_d = fill_q - cnt_t'(1);
            default: fill_d = fill_q;
        endcase

        drop_d = drop_q;
        if (drop && (drop_q != '1))
            drop_d = drop_q + CNT_W'(1);

        r_vld_d = r_vld_q;
        if (rd_en)
            r_vld_d = 1'b1;
        else if (out_adv)
            r_vld_d = 1'b0;

        m_vld_d  = out_adv ? r_vld_q : m_vld_q;
        m_data_d = (out_adv && r_vld_q) ? rdata_q : m_data_q;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            wr_q     <= '0;
            cm_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
            drop_q   <= '0;
            r_vld_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
        end else begin
            wr_q     <= wr_d;
            cm_q     <= cm_d;
            rd_q     <= rd_d;
            fill_q   <= fill_d;
            drop_q   <= drop_d;
            r_vld_q  <= r_vld_d;
            m_vld_q  <= m_vld_d;
            m_data_q <= m_data_d;
        end
    end

    // Simple-dual-port RAM with an enabled read register; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_q[AW-1:0]] <= xf_byte;
        if (rd_en)
            rdata_q <= mem[rd_q[AW-1:0]];
    end

    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_data_q;
    assign fill          = fill_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_axis_echo_xform.sv
// Directed + random bench for axis_echo_xform (DEPTH=16) with an expected-byte queue.
module tb_axis_echo_xform;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             sresetn;
    logic [1:0]       mode;
    logic             line_mode;
    logic             s_tvalid;
    logic [7:0]       s_tdata;
    logic             m_tready;
    logic             m_tvalid;
    logic [7:0]       m_tdata;
    logic [4:0]       fill;
    logic [CNT_W-1:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    axis_echo_xform #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .sresetn       (sresetn),
        .mode          (mode),
        .line_mode     (line_mode),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .m_axis_tready (m_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .fill          (fill),
        .drop_count    (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit push, input logic [7:0] e);
        s_tvalid = 1'b1;
        s_tdata  = b;
        if (push) exp_q.push_back(e);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic send_str(input string in, input string ex, input bit push);
        for (int i = 0; i < in.len(); i++)
            send(in[i], push, push ? ex[i] : 8'h00);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: handshakes are judged at the negedge preceding the transfer edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_vld", 32'(m_tvalid), 32'd1);
            check("stall_data", 32'(m_tdata), 32'(prev_data));
        end
        if (sresetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL spurious_out: observed %0h expected none", m_tdata);
            end else begin
                check("out_data", 32'(m_tdata), 32'(exp_q.pop_front()));
            end
        end
        prev_stall = sresetn && m_tvalid && !m_tready;
        prev_data  = m_tdata;
    end

    initial begin
        int   sent;
        logic [7:0] b;

        // Reset, with input strobes that must be ignored
        sresetn = 1'b0; mode = 2'd0; line_mode = 1'b0;
        s_tvalid = 1'b1; s_tdata = 8'h55; m_tready = 1'b1;
        repeat (3) tick();
        s_tvalid = 1'b0;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        sresetn = 1'b1;
        repeat (3) tick();
        check("rst_ignored_fill", 32'(fill), 32'd0);
        check("rst_ignored_vld", 32'(m_tvalid), 32'd0);

        // Upper mode and first-byte latency
        mode = 2'd2;
        s_tvalid = 1'b1; s_tdata = "a"; exp_q.push_back("A");
        tick(); check("lat_edge0", 32'(m_tvalid), 32'd0);
        s_tdata = "B"; exp_q.push_back("B");
        tick(); check("lat_edge1", 32'(m_tvalid), 32'd0);
        s_tdata = "1"; exp_q.push_back("1");
        tick(); check("lat_edge2", 32'(m_tvalid), 32'd1);
        s_tdata = "z"; exp_q.push_back("Z");
        tick(); s_tvalid = 1'b0;
        wait_drain("upper_drain");

        // Invert and lower, including letter-range boundaries
        mode = 2'd1;
        send_str("Hello!", "hELLO!", 1'b1);
        wait_drain("inv_drain");
        mode = 2'd3;
        send_str("A@[`{Z", "a@[`{z", 1'b1);
        wait_drain("lower_drain");

        // Line mode hold until CR
        mode = 2'd0; line_mode = 1'b1;
        send_str("abc", "abc", 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("line_hold_vld", 32'(m_tvalid), 32'd0);
        end
        check("line_hold_fill", 32'(fill), 32'd3);
        send(8'h0D, 1'b1, 8'h0D);
        wait_drain("line_cr_drain");

        // Forced flush on full, overflow drops while stalled
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++)
            send(8'(8'h30 + i), i < DEPTH, 8'(8'h30 + i));
        repeat (3) tick();
        check("flush_fill", 32'(fill), 32'd16);
        check("flush_drop", 32'(drop_count), 32'd4);
        check("flush_vld", 32'(m_tvalid), 32'd1);
        m_tready = 1'b1;
        wait_drain("flush_drain");
        tick();
        check("flush_fill_empty", 32'(fill), 32'd0);

        // Leaving line mode commits the pending partial line
        send_str("xy", "xy", 1'b1);
        repeat (5) tick();
        check("lm_partial_hold", 32'(m_tvalid), 32'd0);
        line_mode = 1'b0;
        wait_drain("lm_exit_drain");

        // Reset mid-line discards buffered bytes
        line_mode = 1'b1;
        send_str("qrstu", "", 1'b0);
        check("mid_fill", 32'(fill), 32'd5);
        sresetn = 1'b0;
        tick();
        sresetn = 1'b1;
        check("mid_rst_vld", 32'(m_tvalid), 32'd0);
        check("mid_rst_fill", 32'(fill), 32'd0);
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        line_mode = 1'b0;
        repeat (20) tick();
        check("mid_rst_after_fill", 32'(fill), 32'd0);

        // Random backpressure, pass mode, paced so the buffer never overflows
        mode = 2'd0;
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            if (exp_q.size() < 12 && $urandom_range(0, 2) != 0) begin
                b = 8'($urandom);
                s_tvalid = 1'b1;
                s_tdata  = b;
                exp_q.push_back(b);
                sent++;
            end else begin
                s_tvalid = 1'b0;
            end
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        wait_drain("rand_drain");
        check("rand_sent", 32'(sent), 32'd1000);
        check("rand_drop", 32'(drop_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
